// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, the zero-register index and the write-back request type
// Items: DATA_W (register width), ADDR_W (register index width), REG_ZERO (hard-wired zero
//        register index), wb_req_t (one buffered write: destination index + data)
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wbuf_fifo.sv
// wbuf_fifo: circular write-buffer FIFO that exposes every entry for read forwarding
// Ports: clk, reset (async, active-high); push_i/din_i enqueue at tail; pop_i removes head;
//        front_o is the head entry; ent_o/vld_o give all entries and their occupancy;
//        age_o is each slot's position counted from the oldest (0 = oldest); count_o
//        is the number of occupied slots.
module wbuf_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  wb_req_t       din_i,
  output wb_req_t       front_o,
  output wb_req_t       ent_o [DEPTH],
  output logic [DEPTH-1:0] vld_o,
  output logic [PW-1:0] age_o [DEPTH],
  output logic [CW-1:0] count_o
);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  wb_req_t mem_q [DEPTH];
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    head_d  = pop_i ? inc(head_q) : head_q;
    tail_d  = push_i ? inc(tail_q) : tail_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // Payload needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= din_i;
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign ent_o[i] = mem_q[i];
    assign age_o[i] = PW'((i + DEPTH - int'(head_q)) % DEPTH);
    assign vld_o[i] = ((i + DEPTH - int'(head_q)) % DEPTH) < int'(count_q);
  end
  assign front_o = mem_q[head_q];
  assign count_o = count_q;
endmodule

// File: rtl/mips_regfile_wbuf.sv
// mips_regfile_wbuf: MIPS register file fed by a buffered valid/ready write-back port
// Ports: clk, reset (async, active-high); read_reg_1/2 -> read_data_1/2 (combinational,
//        forwarded from pending writes); wb_valid/wb_ready/wb_reg/wb_data write-back
//        handshake; hold blocks the drain into the array; buf_count/busy report backlog.
module mips_regfile_wbuf
  import mips_pkg::wb_req_t, mips_pkg::REG_ZERO;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int BUF_DEPTH = 2,
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1,
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              hold,
  output logic [CW-1:0]     buf_count,
  output logic              busy
);
  logic [DATA_W-1:0] regs_q [2**ADDR_W];
  wb_req_t front, ent [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] vld;
  logic [PW-1:0] age [BUF_DEPTH];
  logic push, pop;
  // Ready comes from the registered count only, so a full buffer never passes through.
  assign wb_ready = buf_count < CW'(BUF_DEPTH);
  assign busy     = buf_count != '0;
  // Writes to the zero register finish the handshake but are dropped here.
  assign push     = wb_valid & wb_ready & (wb_reg != REG_ZERO);
  assign pop      = busy & ~hold;
  wbuf_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ('{addr: wb_reg, data: wb_data}),
    .front_o (front),
    .ent_o   (ent),
    .vld_o   (vld),
    .age_o   (age),
    .count_o (buf_count)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '{default: '0};
    else if (pop) regs_q[front.addr] <= front.data;
  end
  // Youngest matching pending entry wins over older entries and over the array.
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] r);
    logic hit;
    logic [PW-1:0] best;
    rd   = regs_q[r];
    hit  = 1'b0;
    best = '0;
    for (int k = 0; k < BUF_DEPTH; k++)
      if (vld[k] && ent[k].addr == r && (!hit || age[k] > best)) begin
        hit  = 1'b1;
        best = age[k];
        rd   = ent[k].data;
      end
    if (r == REG_ZERO) rd = '0;
  endfunction
  always_comb begin
    read_data_1 = rd(read_reg_1);
    read_data_2 = rd(read_reg_2);
  end
endmodule

// File: tb/tb_mips_regfile_wbuf.sv
// tb_mips_regfile_wbuf: scoreboard bench for the buffered register file
module tb_mips_regfile_wbuf;
  logic clk = 0, reset = 1;
  logic [4:0] rr1 = 0, rr2 = 0, wb_reg = 0;
  logic [31:0] rd1, rd2, wb_data = 0;
  logic wb_valid = 0, wb_ready, hold = 0, busy;
  logic [1:0] cnt;
  int checks = 0, fails = 0;

  typedef struct { string name; int kind; logic [31:0] v; } item_t;
  item_t sb[$];
  typedef struct { int r; logic [31:0] d; } pend_t;
  pend_t pend[$];
  logic [31:0] arr [32];

  mips_regfile_wbuf dut (
    .clk(clk), .reset(reset), .read_reg_1(rr1), .read_reg_2(rr2),
    .read_data_1(rd1), .read_data_2(rd2), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_reg(wb_reg), .wb_data(wb_data), .hold(hold), .buf_count(cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // kind: 0 read_data_1, 1 read_data_2, 2 buf_count, 3 wb_ready, 4 busy
  task automatic exp(input string n, input int k, input logic [31:0] v);
    sb.push_back('{n, k, v});
  endtask

  task automatic exp_st(input string n, input int c, input bit r);
    exp(n, 2, 32'(c));
    exp(n, 3, {31'b0, r});
    exp(n, 4, {31'b0, c != 0});
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0) begin
      item_t it;
      logic [31:0] act;
      it = sb.pop_front();
      act = it.kind == 0 ? rd1 : it.kind == 1 ? rd2 : it.kind == 2 ? 32'(cnt) :
            it.kind == 3 ? {31'b0, wb_ready} : {31'b0, busy};
      checks++;
      if (act !== it.v) begin
        fails++;
        $display("FAIL %s (kind %0d): got %h expected %h at %0t", it.name, it.kind, act, it.v, $time);
      end
    end
  end

  function automatic logic [31:0] mread(input int r);
    if (r == 0) return 0;
    for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].r == r) return pend[i].d;
    return arr[r];
  endfunction

  // Reference behaviour for one clock edge, applied from the inputs of the current cycle.
  task automatic tick();
    bit acc;
    if (!reset) begin
      acc = wb_valid && pend.size() < 2;
      if (pend.size() > 0 && !hold) begin
        arr[pend[0].r] = pend[0].d;
        void'(pend.pop_front());
      end
      if (acc && wb_reg != 0) pend.push_back('{int'(wb_reg), wb_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int r, input logic [31:0] d);
    wb_valid = 1; wb_reg = 5'(r); wb_data = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) arr[i] = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    // 1: reset state and zero-register write
    exp_st("reset_state", 0, 1);
    for (int r = 0; r < 32; r += 2) begin
      rr1 = 5'(r); rr2 = 5'(r + 1);
      exp("reset_read_a", 0, 0);
      exp("reset_read_b", 1, 0);
      tick();
    end
    wr(0, 32'hFFFF_FFFF); rr1 = 0;
    exp("r0_ready", 3, 1);
    tick();
    wb_valid = 0;
    exp_st("r0_discard", 0, 1);
    exp("r0_read", 0, 0);
    tick();
    // 2: single write, forwarding then array
    wr(5, 32'h1234_5678); rr1 = 5;
    exp("r5_same_cycle", 0, 0);
    exp_st("r5_accept", 0, 1);
    tick();
    wb_valid = 0;
    exp("r5_forward", 0, 32'h1234_5678);
    exp_st("r5_pending", 1, 1);
    tick();
    exp("r5_array", 0, 32'h1234_5678);
    exp_st("r5_drained", 0, 1);
    tick();
    // 3: hold fills buffer, back-pressure, ordered drain
    hold = 1; wr(3, 32'hA); rr1 = 3; rr2 = 4;
    exp("r3_before", 0, 0);
    tick();
    wr(3, 32'hB);
    exp("r3_fwd_a", 0, 32'hA);
    exp_st("hold_one", 1, 1);
    tick();
    wr(4, 32'hC);
    exp("r3_fwd_b", 0, 32'hB);
    exp("r4_none", 1, 0);
    exp_st("hold_full", 2, 0);
    tick();
    exp_st("hold_full2", 2, 0);
    tick();
    hold = 0;
    exp_st("release", 2, 0);
    exp("r3_release", 0, 32'hB);
    tick();
    exp_st("r4_accept", 1, 1);
    exp("r3_after_a", 0, 32'hB);
    exp("r4_not_fwd", 1, 0);
    tick();
    wb_valid = 0;
    exp_st("r4_pending", 1, 1);
    exp("r3_array_b", 0, 32'hB);
    exp("r4_fwd", 1, 32'hC);
    tick();
    exp_st("hold_drained", 0, 1);
    exp("r4_array", 1, 32'hC);
    tick();
    // 4: simultaneous accept and drain, then wrap-around traffic
    wr(10, 1); tick();
    wr(11, 2); exp_st("sim_1", 1, 1); tick();
    wr(12, 3); exp_st("sim_2", 1, 1); tick();
    wb_valid = 0; rr1 = 10; rr2 = 11;
    exp_st("sim_3", 1, 1);
    exp("sim_r10", 0, 1);
    exp("sim_r11", 1, 2);
    tick();
    rr1 = 12;
    exp("sim_r12", 0, 3);
    exp_st("sim_done", 0, 1);
    tick();
    for (int i = 0; i < 20; i++) begin
      wr(20 + i % 4, 32'(100 + i));
      tick();
    end
    wb_valid = 0;
    tick();
    for (int r = 0; r < 4; r += 2) begin
      rr1 = 5'(20 + r); rr2 = 5'(21 + r);
      exp("wrap_a", 0, 32'(116 + r));
      exp("wrap_b", 1, 32'(117 + r));
      tick();
    end
    exp_st("wrap_empty", 0, 1);
    // 5: async reset discards pending writes
    hold = 1; wr(7, 32'h77); tick();
    wr(8, 32'h88); tick();
    wb_valid = 0; rr1 = 7; rr2 = 8;
    exp_st("rst_full", 2, 0);
    exp("rst_r7_fwd", 0, 32'h77);
    exp("rst_r8_fwd", 1, 32'h88);
    tick();
    #1 reset = 1;
    pend.delete();
    for (int i = 0; i < 32; i++) arr[i] = 0;
    exp_st("rst_async", 0, 1);
    exp("rst_r7", 0, 0);
    exp("rst_r8", 1, 0);
    @(posedge clk);
    #1 reset = 0; hold = 0;
    exp("rst_r7_after", 0, 0);
    exp("rst_r5_after", 1, 0);
    rr2 = 5;
    tick();
    // 6: random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      hold = $urandom_range(9) < 3;
      wb_valid = $urandom_range(9) < 6;
      wb_reg = 5'($urandom_range(7));
      wb_data = $urandom;
      rr1 = 5'($urandom_range(7));
      rr2 = 5'($urandom_range(7));
      exp("rand_rd1", 0, mread(int'(rr1)));
      exp("rand_rd2", 1, mread(int'(rr2)));
      exp_st("rand_state", pend.size(), pend.size() < 2);
      tick();
    end
    wb_valid = 0; hold = 0;
    repeat (3) tick();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d items left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
